// File: rtl/multdiv_alu_sequencer.sv
// multdiv_alu_sequencer: Booth multiply / restoring divide sequenced through the shared 32-bit ALU
module multdiv_alu_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow
);
  typedef enum logic [2:0] {IDLE, MUL_STEP, DIV_ABSA, DIV_ABSB, DIV_STEP, DIV_FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [31:0] x_q, x_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic qb_q, qb_d, neg_q, neg_d, dz_q, dz_d, dov_q, dov_d, exc_q, exc_d;
  logic [31:0] t;
  logic ge, c;
  // x holds M (multiply) or D (divide); hi/lo hold hi/lo (multiply) or R/Q (divide)
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    x_d = x_q;
    hi_d = hi_q;
    lo_d = lo_q;
    res_d = res_q;
    qb_d = qb_q;
    neg_d = neg_q;
    dz_d = dz_q;
    dov_d = dov_q;
    exc_d = exc_q;
    alu_operandA = '0;
    alu_operandB = '0;
    alu_opcode = '0;
    t = {hi_q[30:0], lo_q[31]};
    c = alu_result[31] ^ alu_overflow;
    ge = (t[31] == x_q[31]) ? ~alu_result[31] : t[31];
    case (state_q)
      IDLE: if (ctrl_MULT || ctrl_DIV) begin
        x_d = data_operandA;
        lo_d = data_operandB;
        hi_d = '0;
        qb_d = 1'b0;
        count_d = '0;
        state_d = ctrl_MULT ? MUL_STEP : DIV_ABSA;
      end
      MUL_STEP: begin
        alu_operandA = hi_q;
        alu_operandB = (lo_q[0] ^ qb_q) ? x_q : '0;
        alu_opcode = {4'b0, lo_q[0] & ~qb_q};
        hi_d = {c, alu_result[31:1]};
        lo_d = {alu_result[0], lo_q[31:1]};
        qb_d = lo_q[0];
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = DONE;
          res_d = lo_d;
          exc_d = hi_d != {32{lo_d[31]}};
        end
      end
      DIV_ABSA: begin
        alu_operandA = x_q[31] ? '0 : x_q;
        alu_operandB = x_q[31] ? x_q : '0;
        alu_opcode = {4'b0, x_q[31]};
        hi_d = alu_result;
        neg_d = x_q[31] ^ lo_q[31];
        dz_d = lo_q == '0;
        dov_d = (x_q == 32'h8000_0000) && (lo_q == 32'hFFFF_FFFF);
        state_d = DIV_ABSB;
      end
      DIV_ABSB: begin
        alu_operandA = lo_q[31] ? '0 : lo_q;
        alu_operandB = lo_q[31] ? lo_q : '0;
        alu_opcode = {4'b0, lo_q[31]};
        x_d = alu_result;
        lo_d = hi_q;
        hi_d = '0;
        count_d = '0;
        state_d = DIV_STEP;
      end
      DIV_STEP: begin
        alu_operandA = t;
        alu_operandB = x_q;
        alu_opcode = 5'b00001;
        hi_d = ge ? alu_result : t;
        lo_d = {lo_q[30:0], ge};
        count_d = count_q + 5'd1;
        state_d = (count_q == 5'd31) ? DIV_FIX : DIV_STEP;
      end
      DIV_FIX: begin
        alu_operandA = neg_q ? '0 : lo_q;
        alu_operandB = neg_q ? lo_q : '0;
        alu_opcode = {4'b0, neg_q};
        res_d = dz_q ? '0 : alu_result;
        exc_d = dz_q | dov_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      x_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      res_q <= '0;
      qb_q <= 1'b0;
      neg_q <= 1'b0;
      dz_q <= 1'b0;
      dov_q <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      x_q <= x_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      res_q <= res_d;
      qb_q <= qb_d;
      neg_q <= neg_d;
      dz_q <= dz_d;
      dov_q <= dov_d;
      exc_q <= exc_d;
    end
  end
  assign data_result = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = state_q == DONE;
  assign busy = state_q != IDLE;
  assign alu_shiftamt = '0;
endmodule

// File: tb/tb_multdiv_alu_sequencer.sv
// tb_multdiv_alu_sequencer: directed vectors with a queue scoreboard; the bench models the shared ALU
module tb_multdiv_alu_sequencer;
  logic clock = 1'b0, reset = 1'b0, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [31:0] data_result, alu_operandA, alu_operandB, alu_result;
  logic data_exception, data_resultRDY, busy, alu_overflow;
  logic [4:0] alu_opcode, alu_shiftamt;
  int cyc = 0, tests = 0, failed = 0;
  typedef struct {logic [31:0] r; logic e; int lat; int t0; string n;} exp_t;
  exp_t sb[$];

  multdiv_alu_sequencer dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt),
    .alu_result(alu_result), .alu_overflow(alu_overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always_comb begin
    alu_result = (alu_opcode == 5'd1) ? alu_operandA - alu_operandB : alu_operandA + alu_operandB;
    alu_overflow = (alu_opcode == 5'd1)
      ? (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31])
      : (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  always @(negedge clock) if (data_resultRDY) begin
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL unexpected_rdy: pulse at cycle %0d with no operation pending", cyc);
    end else begin
      exp_t e;
      e = sb.pop_front();
      chk({e.n, "_result"}, data_result, e.r);
      chk({e.n, "_exception"}, {31'b0, data_exception}, {31'b0, e.e});
      chk({e.n, "_latency"}, cyc - e.t0, e.lat);
    end
  end

  task automatic run(input string n, input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ee, input int lat, input int mult_at);
    int busy_bad;
    bit done;
    busy_bad = 0;
    done = 0;
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    sb.push_back('{er, ee, lat, cyc, n});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
    for (int i = 1; i <= 60 && !done; i++) begin
      if (!busy) busy_bad++;
      if (data_resultRDY) done = 1;
      else begin
        ctrl_MULT = (i == mult_at);
        @(negedge clock);
      end
    end
    ctrl_MULT = 1'b0;
    chk({n, "_rdy_seen"}, {31'b0, done}, 32'd1);
    chk({n, "_busy_throughout"}, busy_bad, 32'd0);
    @(negedge clock);
    chk({n, "_busy_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_flags", {28'b0, data_exception, data_resultRDY, busy, 1'b0}, 32'd0);
    chk("idle_alu_a", alu_operandA, 32'd0);
    chk("idle_alu_b", alu_operandB, 32'd0);
    chk("idle_alu_op", {27'b0, alu_opcode}, 32'd0);
    reset = 1'b1;
    run("mul_6x7",      1, 0, 32'd6,          32'd7,          32'h0000_002A, 0, 33, 0);
    run("mul_m3x5",     1, 0, -32'sd3,        32'd5,          32'hFFFF_FFF1, 0, 33, 0);
    run("mul_ovf",      1, 0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1, 33, 0);
    run("mul_min",      1, 0, 32'h8000_0000,  32'd1,          32'h8000_0000, 0, 33, 0);
    run("div_100_7",    0, 1, 32'd100,        32'd7,          32'd14,        0, 36, 0);
    run("div_m7_2",     0, 1, -32'sd7,        32'd2,          32'hFFFF_FFFD, 0, 36, 0);
    run("div_ovf",      0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1, 36, 0);
    run("div_by_zero",  0, 1, 32'd5,          32'd0,          32'd0,         1, 36, 10);
    run("mul_div_both", 1, 1, 32'd2,          32'd3,          32'd6,         0, 33, 0);
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_flags", {29'b0, data_exception, data_resultRDY, busy}, 32'd0);
    repeat (40) @(negedge clock);
    chk("midreset_no_rdy_pending", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
